rs_dispatch_queue: RTL and testbench
====================================

RS_DISPATCH_QUEUE -- requirements
Module: rs_dispatch_queue

Interface
REQ-001 Parameter DEPTH, default 4: entries per channel queue; power of two, >=2.
REQ-002 Parameter PAYLOAD_W, default 128: opaque instruction bundle width (operands, phy regs, valid, immediate, inst_num, control bits).
REQ-003 Channel map, fixed: ch0 ALU, ch1 MUL, ch2 DIV, ch3 BR; NUM_CH=4.
REQ-004 Single clock; reset is synchronous and active-high; ports clk and reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 flush  input  1  mispredict flush: discard all queued entries.
REQ-008 in_valid  input  1  upstream instruction valid.
REQ-009 in_ready  output  1  instruction accepted this cycle when in_valid && in_ready.
REQ-010 in_opcode  input  7  classification opcode.
REQ-011 in_func3  input  3  classification func3.
REQ-012 in_funct7  input  7  classification funct7.
REQ-013 in_payload  input  PAYLOAD_W  bundle stored unmodified.
REQ-014 out_valid  output  4  per-channel head valid, bit c = channel c.
REQ-015 out_ready  input  4  per-channel downstream RS accept.
REQ-016 out_payload  output  4*PAYLOAD_W  per-channel head bundle, channel c at bits [c*PAYLOAD_W +: PAYLOAD_W].
REQ-017 out_count  output  4*($clog2(DEPTH)+1)  per-channel occupancy, same packing.
REQ-018 drop_cnt  output  16  count of accepted bubble (opcode 0) instructions.

Function
REQ-019 Target channel is combinational from the inputs: opcode 0000000 -> bubble; opcode 0110011 && funct7 0000001 && func3 000 -> MUL; opcode 0110011 && funct7 0000001 && func3 100 or 110 -> DIV; opcode 1101111, 1100111 or 1100011 -> BR; everything else, including other funct7 0000001 func3 values -> ALU.
REQ-020 in_ready = !flush && (target is bubble || count[target] < DEPTH); dequeue in the same cycle does not free space for an enqueue (no full-queue pass-through).
REQ-021 An accepted non-bubble instruction is written at the tail of its target queue on that edge; out_valid[target] is asserted no earlier than the next cycle (1-cycle latency, no bypass).
REQ-022 An accepted bubble is consumed without enqueue; drop_cnt increments by 1 and wraps from 0xFFFF to 0.
REQ-023 out_valid[c] = (count[c] != 0); out_payload for channel c is the oldest entry while out_valid[c]=1 and all-zero otherwise.
REQ-024 Dequeue on channel c when out_valid[c] && out_ready[c]; the head advances on that edge; out_ready while empty is ignored.
REQ-025 A simultaneous enqueue and dequeue on one channel leaves count unchanged and preserves FIFO order.
REQ-026 Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-027 Channels are fully independent: a full channel stalls only instructions that target it.
REQ-028 flush=1 sets every count and pointer to 0 on that edge; the same-cycle enqueue is blocked (in_ready=0) and the same-cycle dequeue is discarded; drop_cnt is unaffected.
REQ-029 Each channel is a 2-state controller derived from count: EMPTY (count=0) and NONEMPTY; FULL is the NONEMPTY sub-condition count=DEPTH, which gates in_ready.

Reset
REQ-030 On reset=1 at a rising edge: all counts and pointers = 0, out_valid=0000, out_payload=0, drop_cnt=0; reset overrides flush and all handshakes.
REQ-031 After reset deasserts, in_ready=1 in the first cycle with flush=0.
REQ-032 A reset in the middle of operation discards all queued entries; no entry queued before the reset appears after it.

Verification
REQ-033 Reset, then a MUL (0110011/0000001/000) with payload 0xA5 -> next cycle out_valid=0010, ch1 payload 0xA5, out_count ch1=1.
REQ-034 DEPTH=4; enqueue 4 BR (1100011) with out_ready=0 -> a 5th BR sees in_ready=0 while an ALU (0010011) sees in_ready=1; out_count ch3=4.
REQ-035 Full ch0 with out_ready[0]=1 and in_valid ALU -> in_ready=0 that cycle, count 4->3, then 3->3 on the next cycle with simultaneous enqueue/dequeue; order preserved.
REQ-036 Enqueue payloads 1..9 on ch2 (DIV and REM mixed) while draining at 1/2 rate -> output order 1..9; pointers wrap without loss.
REQ-037 Queues hold 2/1/3/1 entries and flush=1 with in_valid=1 -> in_ready=0; next cycle out_valid=0000 and all counts 0.
REQ-038 65537 bubble (opcode 0) accepts -> drop_cnt=1; no out_valid ever asserted.

Source files
------------

// File: rtl/rs_dispatch_queue.sv
// Dispatch stage in front of the reservation stations: classifies each incoming
// instruction bundle and queues it in one of four per-unit FIFOs (ALU/MUL/DIV/BR).
module rs_dispatch_queue #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 128
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [6:0]                        in_opcode,
  input  logic [2:0]                        in_func3,
  input  logic [6:0]                        in_funct7,
  input  logic [PAYLOAD_W-1:0]              in_payload,
  output logic [3:0]                        out_valid,
  input  logic [3:0]                        out_ready,
  output logic [4*PAYLOAD_W-1:0]            out_payload,
  output logic [4*($clog2(DEPTH)+1)-1:0]    out_count,
  output logic [15:0]                       drop_cnt
);

  localparam int NUM_CH = 4;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {
    TGT_ALU    = 3'd0,
    TGT_MUL    = 3'd1,
    TGT_DIV    = 3'd2,
    TGT_BR     = 3'd3,
    TGT_BUBBLE = 3'd4
  } target_e;

  typedef enum logic {
    CH_EMPTY,
    CH_NONEMPTY
  } ch_state_e;

  localparam logic [6:0] OP_BUBBLE = 7'b0000000;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  logic [PAYLOAD_W-1:0] mem     [NUM_CH][DEPTH];
  logic [PTR_W-1:0]     wr_ptr  [NUM_CH];
  logic [PTR_W-1:0]     rd_ptr  [NUM_CH];
  logic [CNT_W-1:0]     count   [NUM_CH];
  ch_state_e            ch_state[NUM_CH];

  target_e     target;
  logic        is_bubble;
  logic [1:0]  tgt_idx;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] enq;
  logic [NUM_CH-1:0] deq;
  logic        accept;

  // NOTE: every signal driven from always_comb gets a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    target = TGT_ALU;
    if (in_opcode == OP_BUBBLE) begin
      target = TGT_BUBBLE;
    end else if (in_opcode == OP_RTYPE && in_funct7 == F7_MULDIV) begin
      if (in_func3 == 3'b000)
        target = TGT_MUL;
      else if (in_func3 == 3'b100 || in_func3 == 3'b110)
        target = TGT_DIV;
    end else if (in_opcode == OP_JAL || in_opcode == OP_JALR || in_opcode == OP_BRANCH) begin
      target = TGT_BR;
    end
    is_bubble = (target == TGT_BUBBLE);
    tgt_idx   = target[1:0];
  end

  // Per-channel controller: EMPTY/NONEMPTY follows occupancy, FULL gates intake.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_state[c] = (count[c] != '0) ? CH_NONEMPTY : CH_EMPTY;
      full[c]     = (count[c] == CNT_W'(DEPTH));
      out_valid[c] = (ch_state[c] == CH_NONEMPTY);
      deq[c]       = out_valid[c] && out_ready[c];
      out_payload[c*PAYLOAD_W +: PAYLOAD_W] = out_valid[c] ? mem[c][rd_ptr[c]] : '0;
      out_count[c*CNT_W +: CNT_W]           = count[c];
    end
  end

  // A full queue stays closed even if it drains this cycle: no pass-through.
  assign in_ready = !flush && (is_bubble || !full[tgt_idx]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      enq[c] = accept && !is_bubble && (tgt_idx == 2'(c));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        count[c]  <= '0;
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
      drop_cnt <= '0;
    end else if (flush) begin
      for (int c = 0; c < NUM_CH; c++) begin
        count[c]  <= '0;
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (enq[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (deq[c]) rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        case ({enq[c], deq[c]})
          2'b10:   count[c] <= count[c] + CNT_W'(1);
          2'b01:   count[c] <= count[c] - CNT_W'(1);
          default: count[c] <= count[c];
        endcase
      end
      if (accept && is_bubble) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy and pointers
  // define what is valid, and unused slots are masked to zero on the outputs.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (enq[c]) mem[c][wr_ptr[c]] <= in_payload;
    end
  end

endmodule

// File: tb/tb_rs_dispatch_queue.sv
// Directed bench for rs_dispatch_queue: stimulus pushes expected bundles into
// per-channel scoreboards, a negedge monitor pops and compares on handshakes.
module tb_rs_dispatch_queue;

  localparam int DEPTH = 4;
  localparam int PW    = 128;
  localparam int CW    = $clog2(DEPTH) + 1;

  localparam logic [6:0] OP_ALU  = 7'b0010011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] F7_M    = 7'b0000001;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [2:0]        in_func3;
  logic [6:0]        in_funct7;
  logic [PW-1:0]     in_payload;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [4*PW-1:0]   out_payload;
  logic [4*CW-1:0]   out_count;
  logic [15:0]       drop_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_ch   = 4;          // channel the bench expects the current input to go to; 4 = bubble
  int pops[4]  = '{0, 0, 0, 0};
  logic [PW-1:0] sb[4][$];
  logic [15:0]   m_drop = '0;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         ch;
  } vec_t;

  rs_dispatch_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_func3   (in_func3),
    .in_funct7  (in_funct7),
    .in_payload (in_payload),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(out_payload),
    .out_count  (out_count),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [PW-1:0] pl, input int ch);
    in_valid   = v;
    in_opcode  = op;
    in_func3   = f3;
    in_funct7  = f7;
    in_payload = pl;
    exp_ch     = ch;
  endtask

  task automatic idle();
    drive(1'b0, 7'd0, 3'd0, 7'd0, '0, 4);
  endtask

  task automatic do_reset();
    step();
    idle();
    flush     = 1'b0;
    out_ready = 4'b0;
    reset     = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    step();
    idle();
    out_ready = 4'hF;
    @(negedge clk);
    while (out_valid != 4'b0 && n < 40) begin
      step();
      @(negedge clk);
      n++;
    end
    check({"drain_", tag}, 128'(out_valid), 128'(0));
    step();
    out_ready = 4'b0;
  endtask

  // Monitor: compares DUT state against the scoreboard, then applies this
  // cycle's handshakes (pops before pushes, since enqueues show up a cycle later).
  always @(negedge clk) begin
    if (reset) begin
      for (int c = 0; c < 4; c++) sb[c].delete();
      m_drop = '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("count_ch%0d", c), 128'(out_count[c*CW +: CW]), 128'(sb[c].size()));
        check($sformatf("valid_ch%0d", c), 128'(out_valid[c]), 128'(sb[c].size() != 0));
        if (sb[c].size() != 0)
          check($sformatf("head_ch%0d", c), out_payload[c*PW +: PW], sb[c][0]);
        else
          check($sformatf("idle_payload_ch%0d", c), out_payload[c*PW +: PW], '0);
      end
      check("drop_cnt", 128'(drop_cnt), 128'(m_drop));
      if (flush) begin
        for (int c = 0; c < 4; c++) sb[c].delete();
      end else begin
        for (int c = 0; c < 4; c++) begin
          if (out_valid[c] && out_ready[c] && sb[c].size() != 0) begin
            void'(sb[c].pop_front());
            pops[c]++;
          end
        end
        if (in_valid && in_ready) begin
          if (exp_ch == 4) m_drop = m_drop + 16'd1;
          else             sb[exp_ch].push_back(in_payload);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t route[13];
    vec_t load[8];
    int   nxt, cyc, stalls, pops_before;

    route[0]  = '{OP_ALU,  3'b000, 7'd0, 0};
    route[1]  = '{OP_R,    3'b000, 7'd0, 0};
    route[2]  = '{OP_R,    3'b000, F7_M, 1};
    route[3]  = '{OP_R,    3'b100, F7_M, 2};
    route[4]  = '{OP_R,    3'b110, F7_M, 2};
    route[5]  = '{OP_R,    3'b101, F7_M, 0};
    route[6]  = '{OP_R,    3'b111, F7_M, 0};
    route[7]  = '{OP_R,    3'b001, F7_M, 0};
    route[8]  = '{OP_JAL,  3'b000, 7'd0, 3};
    route[9]  = '{OP_JALR, 3'b000, 7'd0, 3};
    route[10] = '{OP_BR,   3'b001, 7'd0, 3};
    route[11] = '{OP_ALU,  3'b000, F7_M, 0};
    route[12] = '{7'd0,    3'b000, 7'd0, 4};

    reset = 1'b1;
    flush = 1'b0;
    out_ready = 4'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_payload_zero", 128'(|out_payload), 128'(0));
    check("rst_drop_cnt", 128'(drop_cnt), 128'(0));

    // MUL with payload 0xA5 shows up on ch1 one cycle after acceptance.
    step();
    drive(1'b1, OP_R, 3'b000, F7_M, 128'hA5, 1);
    @(negedge clk);
    check("mul_in_ready", 128'(in_ready), 128'(1));
    check("mul_no_bypass", 128'(out_valid), 128'(0));
    step();
    idle();
    @(negedge clk);
    check("mul_out_valid", 128'(out_valid), 128'(4'b0010));
    check("mul_payload", out_payload[1*PW +: PW], 128'hA5);
    check("mul_count", 128'(out_count[1*CW +: CW]), 128'(1));
    drain("mul");

    // Classification table: one instruction at a time, checked by which channel lights up.
    for (int i = 0; i < 13; i++) begin
      step();
      drive(1'b1, route[i].op, route[i].f3, route[i].f7, 128'(32'h100 + i), route[i].ch);
      @(negedge clk);
      check($sformatf("route%0d_in_ready", i), 128'(in_ready), 128'(1));
      step();
      idle();
      @(negedge clk);
      check($sformatf("route%0d_onehot", i), 128'(out_valid),
            128'((route[i].ch == 4) ? 4'b0000 : (4'b0001 << route[i].ch)));
      step();
      out_ready = 4'hF;
      step();
      out_ready = 4'b0;
    end

    // Full BR queue stalls only BR traffic.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_BR, 3'b000, 7'd0, 128'(32'h30 + i), 3);
      step();
    end
    drive(1'b1, OP_BR, 3'b000, 7'd0, 128'h34, 3);
    @(negedge clk);
    check("br_full_in_ready", 128'(in_ready), 128'(0));
    check("br_full_count", 128'(out_count[3*CW +: CW]), 128'(4));
    step();
    drive(1'b1, OP_ALU, 3'b000, 7'd0, 128'h40, 0);
    @(negedge clk);
    check("alu_beside_full_br", 128'(in_ready), 128'(1));
    drain("br");

    // Full ALU queue draining: no pass-through, then simultaneous enq/deq.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_ALU, 3'b000, 7'd0, 128'(32'h50 + i), 0);
      step();
    end
    drive(1'b1, OP_ALU, 3'b000, 7'd0, 128'h54, 0);
    out_ready = 4'b0001;
    @(negedge clk);
    check("alu_full_no_passthru", 128'(in_ready), 128'(0));
    check("alu_full_count4", 128'(out_count[0 +: CW]), 128'(4));
    step();
    @(negedge clk);
    check("alu_after_deq_count3", 128'(out_count[0 +: CW]), 128'(3));
    check("alu_after_deq_ready", 128'(in_ready), 128'(1));
    step();
    idle();
    out_ready = 4'b0;
    @(negedge clk);
    check("alu_enq_deq_count3", 128'(out_count[0 +: CW]), 128'(3));
    check("alu_enq_deq_head", out_payload[0 +: PW], 128'h52);
    drain("alu");

    // Payloads 1..9 on DIV/REM while draining every other cycle; two stalls expected.
    do_reset();
    nxt = 1;
    cyc = 0;
    stalls = 0;
    pops_before = pops[2];
    while (nxt <= 9 && cyc < 100) begin
      drive(1'b1, OP_R, (nxt % 2 == 1) ? 3'b100 : 3'b110, F7_M, 128'(nxt), 2);
      out_ready = {1'b0, cyc[0], 2'b00};
      @(negedge clk);
      if (in_ready) nxt++;
      else          stalls++;
      step();
      cyc++;
    end
    check("div_all_issued", 128'(nxt), 128'(10));
    check("div_stalls", 128'(stalls), 128'(2));
    drain("div");
    check("div_pops", 128'(pops[2] - pops_before), 128'(9));

    // Flush with 2/1/3/1 queued and an instruction offered in the same cycle.
    do_reset();
    load[0] = '{OP_ALU, 3'b000, 7'd0, 0};
    load[1] = '{OP_ALU, 3'b010, 7'd0, 0};
    load[2] = '{OP_R,   3'b000, F7_M, 1};
    load[3] = '{OP_R,   3'b100, F7_M, 2};
    load[4] = '{OP_R,   3'b110, F7_M, 2};
    load[5] = '{OP_R,   3'b100, F7_M, 2};
    load[6] = '{OP_JAL, 3'b000, 7'd0, 3};
    load[7] = '{7'd0,   3'b000, 7'd0, 4};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, load[i].op, load[i].f3, load[i].f7, 128'(32'h60 + i), load[i].ch);
      step();
    end
    idle();
    @(negedge clk);
    check("flush_pre_counts", 128'(out_count), 128'({3'd1, 3'd3, 3'd1, 3'd2}));
    check("flush_pre_drop", 128'(drop_cnt), 128'(1));
    step();
    drive(1'b1, OP_ALU, 3'b000, 7'd0, 128'h6F, 0);
    flush = 1'b1;
    out_ready = 4'hF;
    @(negedge clk);
    check("flush_in_ready", 128'(in_ready), 128'(0));
    step();
    idle();
    flush = 1'b0;
    out_ready = 4'b0;
    @(negedge clk);
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_counts", 128'(out_count), 128'(0));
    check("flush_keeps_drop", 128'(drop_cnt), 128'(1));

    // Reset mid-operation discards queued MULs; new entry is the only one seen.
    step();
    drive(1'b1, OP_R, 3'b000, F7_M, 128'h71, 1);
    step();
    drive(1'b1, OP_R, 3'b000, F7_M, 128'h72, 1);
    step();
    idle();
    flush = 1'b1;
    reset = 1'b1;
    step();
    flush = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_drop", 128'(drop_cnt), 128'(0));
    step();
    drive(1'b1, OP_R, 3'b000, F7_M, 128'h77, 1);
    step();
    idle();
    @(negedge clk);
    check("midrst_new_head", out_payload[1*PW +: PW], 128'h77);
    check("midrst_new_count", 128'(out_count[1*CW +: CW]), 128'(1));
    drain("midrst");

    // 65537 bubbles: drop_cnt passes 0xFFFF and wraps to 1.
    do_reset();
    drive(1'b1, 7'd0, 3'd0, 7'd0, 128'hBB, 4);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    check("bubble_ffff", 128'(drop_cnt), 128'(16'hFFFF));
    check("bubble_in_ready", 128'(in_ready), 128'(1));
    repeat (2) @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    check("bubble_wrap", 128'(drop_cnt), 128'(1));
    check("bubble_no_valid", 128'(out_valid), 128'(0));

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
